// File: rtl/ps2_synth_pkg.sv
// Shared scan codes, prefix-FSM encoding and note lookup for the PS/2 synth keymap.
package ps2_synth_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Note keys (one octave, C..B)
  localparam logic [7:0] SC_NOTE_C  = 8'h1C;
  localparam logic [7:0] SC_NOTE_CS = 8'h1D;
  localparam logic [7:0] SC_NOTE_D  = 8'h1B;
  localparam logic [7:0] SC_NOTE_DS = 8'h24;
  localparam logic [7:0] SC_NOTE_E  = 8'h23;
  localparam logic [7:0] SC_NOTE_F  = 8'h2B;
  localparam logic [7:0] SC_NOTE_FS = 8'h2C;
  localparam logic [7:0] SC_NOTE_G  = 8'h34;
  localparam logic [7:0] SC_NOTE_GS = 8'h35;
  localparam logic [7:0] SC_NOTE_A  = 8'h33;
  localparam logic [7:0] SC_NOTE_AS = 8'h3C;
  localparam logic [7:0] SC_NOTE_B  = 8'h3B;

  localparam logic [3:0] NOTE_C  = 4'd0;
  localparam logic [3:0] NOTE_CS = 4'd1;
  localparam logic [3:0] NOTE_D  = 4'd2;
  localparam logic [3:0] NOTE_DS = 4'd3;
  localparam logic [3:0] NOTE_E  = 4'd4;
  localparam logic [3:0] NOTE_F  = 4'd5;
  localparam logic [3:0] NOTE_FS = 4'd6;
  localparam logic [3:0] NOTE_G  = 4'd7;
  localparam logic [3:0] NOTE_GS = 4'd8;
  localparam logic [3:0] NOTE_A  = 4'd9;
  localparam logic [3:0] NOTE_AS = 4'd10;
  localparam logic [3:0] NOTE_B  = 4'd11;

  // Repeating controls; the EXT_ codes follow an E0 prefix
  localparam logic [7:0] SC_OCT_DN       = 8'h1A;
  localparam logic [7:0] SC_OCT_UP       = 8'h22;
  localparam logic [7:0] SC_EXT_OCT_DN   = 8'h6B;
  localparam logic [7:0] SC_EXT_OCT_UP   = 8'h74;
  localparam logic [7:0] SC_ADSR_DEC     = 8'h21;
  localparam logic [7:0] SC_ADSR_INC     = 8'h2A;
  localparam logic [7:0] SC_EXT_ADSR_DEC = 8'h72;
  localparam logic [7:0] SC_EXT_ADSR_INC = 8'h75;

  // ADSR parameter select
  localparam logic [7:0] SC_SEL_VOL = 8'h16;
  localparam logic [7:0] SC_SEL_ATK = 8'h1E;
  localparam logic [7:0] SC_SEL_DEC = 8'h26;
  localparam logic [7:0] SC_SEL_SUS = 8'h25;
  localparam logic [7:0] SC_SEL_REL = 8'h2E;

  // Press-once toggles
  localparam logic [7:0] SC_SINE    = 8'h36;
  localparam logic [7:0] SC_OD_UP   = 8'h3D;
  localparam logic [7:0] SC_OD_DN   = 8'h3E;
  localparam logic [7:0] SC_SUSTAIN = 8'h45;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } prefix_state_t;

  typedef enum logic [2:0] {
    ADSR_VOL = 3'd0,
    ADSR_ATK = 3'd1,
    ADSR_DEC = 3'd2,
    ADSR_SUS = 3'd3,
    ADSR_REL = 3'd4
  } adsr_sel_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] note;
  } note_lookup_t;

  typedef struct packed {
    logic sine;
    logic od_up;
    logic od_dn;
    logic sustain;
  } toggle_held_t;

  function automatic note_lookup_t note_lookup(input logic [7:0] code);
    note_lookup_t res;
    res.hit  = 1'b1;
    res.note = NOTE_C;
    case (code)
      SC_NOTE_C:  res.note = NOTE_C;
      SC_NOTE_CS: res.note = NOTE_CS;
      SC_NOTE_D:  res.note = NOTE_D;
      SC_NOTE_DS: res.note = NOTE_DS;
      SC_NOTE_E:  res.note = NOTE_E;
      SC_NOTE_F:  res.note = NOTE_F;
      SC_NOTE_FS: res.note = NOTE_FS;
      SC_NOTE_G:  res.note = NOTE_G;
      SC_NOTE_GS: res.note = NOTE_GS;
      SC_NOTE_A:  res.note = NOTE_A;
      SC_NOTE_AS: res.note = NOTE_AS;
      SC_NOTE_B:  res.note = NOTE_B;
      default:    res.hit  = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_voice_alloc.sv
// Polyphonic voice table: match search, lowest-free allocation and sustain release.
// PS2_KEYMAP_VOICE_STEAL_EN replaces a round-robin voice instead of dropping when full.
module ps2_voice_alloc
  import ps2_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_make,
  input  logic                         i_break,
  input  logic [NOTE_W-1:0]            i_note,
  input  logic                         i_sustain,
  input  logic                         i_sustain_fall,
  output logic [NUM_VOICES-1:0]        o_voice_valid,
  output logic [NUM_VOICES*NOTE_W-1:0] o_voice_note,
  output logic [NUM_VOICES-1:0]        o_voice_trig,
  output logic                         o_note_drop
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_VOICES-1:0] r_valid;
  logic [NUM_VOICES-1:0] r_held;
  logic [NUM_VOICES-1:0] r_trig;
  logic [NOTE_W-1:0]     r_note [NUM_VOICES];
  logic                  r_drop;

  logic             w_match_any;
  logic [IDX_W-1:0] w_match_idx;
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;

`ifdef PS2_KEYMAP_VOICE_STEAL_EN
  logic [IDX_W-1:0] r_steal_ptr;
`endif

  // Scanning downward leaves the lowest matching / free index as the winner.
  always_comb begin
    w_match_any = 1'b0;
    w_match_idx = '0;
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_note[i] == i_note)) begin
        w_match_any = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      r_held  <= '0;
      r_trig  <= '0;
      r_drop  <= 1'b0;
      // NOTE: the note table is reset too, because it drives voice_note directly and must read 0 after reset.
      for (int i = 0; i < NUM_VOICES; i++) r_note[i] <= '0;
`ifdef PS2_KEYMAP_VOICE_STEAL_EN
      r_steal_ptr <= '0;
`endif
    end else begin
      r_trig <= '0;
      r_drop <= 1'b0;

      if (i_make) begin
        if (w_match_any) begin
          r_held[w_match_idx] <= 1'b1;
        end else if (w_free_any) begin
          r_valid[w_free_idx] <= 1'b1;
          r_held[w_free_idx]  <= 1'b1;
          r_note[w_free_idx]  <= i_note;
          r_trig[w_free_idx]  <= 1'b1;
        end else begin
`ifdef PS2_KEYMAP_VOICE_STEAL_EN
          r_held[r_steal_ptr] <= 1'b1;
          r_note[r_steal_ptr] <= i_note;
          r_trig[r_steal_ptr] <= 1'b1;
          r_steal_ptr <= (r_steal_ptr == IDX_W'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
`else
          r_drop <= 1'b1;
`endif
        end
      end

      if (i_break && w_match_any) begin
        r_held[w_match_idx] <= 1'b0;
        if (!i_sustain) r_valid[w_match_idx] <= 1'b0;
      end

      // Sustain release frees every voice whose key is no longer down.
      if (i_sustain_fall) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!r_held[i]) r_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_flat
    assign o_voice_note[g*NOTE_W +: NOTE_W] = r_note[g];
  end

  assign o_voice_valid = r_valid;
  assign o_voice_trig  = r_trig;
  assign o_note_drop   = r_drop;

endmodule

// File: rtl/ps2_synth_keymap.sv
// PS/2 scan-code to synth control decoder: F0/E0 prefix tracking, octave, ADSR, toggles.
// Define PS2_KEYMAP_VOICE_STEAL_EN to steal a voice instead of dropping when all are busy.
module ps2_synth_keymap
  import ps2_synth_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int NOTE_W      = 4,
  parameter int OCT_W       = 3,
  parameter int OCT_DEFAULT = 4,
  parameter int OCT_MAX     = 7,
  parameter int OD_W        = 2
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic [NUM_VOICES-1:0]        voice_valid,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic                         note_drop,
  output logic [OCT_W-1:0]             octave,
  output logic [2:0]                   adsr_sel,
  output logic                         adsr_inc,
  output logic                         adsr_dec,
  output logic                         sine,
  output logic [OD_W-1:0]              overdrive,
  output logic                         sustain
);

  prefix_state_t    r_state;
  toggle_held_t     r_held;
  logic [OCT_W-1:0] r_octave;
  adsr_sel_t        r_adsr_sel;
  logic             r_adsr_inc;
  logic             r_adsr_dec;
  logic             r_sine;
  logic [OD_W-1:0]  r_overdrive;
  logic             r_sustain;

  note_lookup_t w_lookup;
  logic         w_make;
  logic         w_break;
  logic         w_ext;
  logic         w_plain_make;
  logic         w_plain_break;
  logic         w_oct_up;
  logic         w_oct_dn;
  logic         w_adsr_inc;
  logic         w_adsr_dec;
  logic         w_sel_load;
  adsr_sel_t    w_sel_val;
  logic         w_sustain_fall;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_make     = 1'b0;
    w_break    = 1'b0;
    w_ext      = 1'b0;
    w_sel_load = 1'b0;
    w_sel_val  = ADSR_VOL;
    if (byte_valid) begin
      case (r_state)
        ST_IDLE:    w_make = (byte_data != SC_BREAK) && (byte_data != SC_EXT) &&
                             (byte_data != SC_PAUSE);
        ST_BRK:     w_break = 1'b1;
        ST_EXT:     begin
                      w_make = (byte_data != SC_BREAK);
                      w_ext  = 1'b1;
                    end
        ST_EXT_BRK: begin
                      w_break = 1'b1;
                      w_ext   = 1'b1;
                    end
        default:    w_make = 1'b0;
      endcase
    end
    if (w_make && !w_ext) begin
      w_sel_load = 1'b1;
      case (byte_data)
        SC_SEL_VOL: w_sel_val = ADSR_VOL;
        SC_SEL_ATK: w_sel_val = ADSR_ATK;
        SC_SEL_DEC: w_sel_val = ADSR_DEC;
        SC_SEL_SUS: w_sel_val = ADSR_SUS;
        SC_SEL_REL: w_sel_val = ADSR_REL;
        default:    w_sel_load = 1'b0;
      endcase
    end
  end

  assign w_lookup       = note_lookup(byte_data);
  assign w_plain_make   = w_make && !w_ext;
  assign w_plain_break  = w_break && !w_ext;
  assign w_oct_up       = w_make && (w_ext ? (byte_data == SC_EXT_OCT_UP) : (byte_data == SC_OCT_UP));
  assign w_oct_dn       = w_make && (w_ext ? (byte_data == SC_EXT_OCT_DN) : (byte_data == SC_OCT_DN));
  assign w_adsr_inc     = w_make && (w_ext ? (byte_data == SC_EXT_ADSR_INC) : (byte_data == SC_ADSR_INC));
  assign w_adsr_dec     = w_make && (w_ext ? (byte_data == SC_EXT_ADSR_DEC) : (byte_data == SC_ADSR_DEC));
  assign w_sustain_fall = w_plain_make && (byte_data == SC_SUSTAIN) && !r_held.sustain && r_sustain;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_held      <= '0;
      r_octave    <= OCT_W'(OCT_DEFAULT);
      r_adsr_sel  <= ADSR_VOL;
      r_adsr_inc  <= 1'b0;
      r_adsr_dec  <= 1'b0;
      r_sine      <= 1'b0;
      r_overdrive <= '0;
      r_sustain   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, whatever the order.
      r_adsr_inc <= w_adsr_inc;
      r_adsr_dec <= w_adsr_dec;

      if (byte_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (byte_data == SC_BREAK)    r_state <= ST_BRK;
            else if (byte_data == SC_EXT) r_state <= ST_EXT;
          end
          ST_EXT:  r_state <= (byte_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end

      if (w_oct_up && (r_octave < OCT_W'(OCT_MAX))) r_octave <= r_octave + 1'b1;
      else if (w_oct_dn && (r_octave != '0))        r_octave <= r_octave - 1'b1;

      if (w_sel_load) r_adsr_sel <= w_sel_val;

      // Toggles act on the first make only; the held flag swallows typematic repeats.
      if (w_plain_make) begin
        case (byte_data)
          SC_SINE: if (!r_held.sine) begin
            r_sine      <= ~r_sine;
            r_held.sine <= 1'b1;
          end
          SC_OD_UP: if (!r_held.od_up) begin
            r_overdrive  <= r_overdrive + 1'b1;
            r_held.od_up <= 1'b1;
          end
          SC_OD_DN: if (!r_held.od_dn) begin
            r_overdrive  <= r_overdrive - 1'b1;
            r_held.od_dn <= 1'b1;
          end
          SC_SUSTAIN: if (!r_held.sustain) begin
            r_sustain      <= ~r_sustain;
            r_held.sustain <= 1'b1;
          end
          default: ;
        endcase
      end

      if (w_plain_break) begin
        case (byte_data)
          SC_SINE:    r_held.sine    <= 1'b0;
          SC_OD_UP:   r_held.od_up   <= 1'b0;
          SC_OD_DN:   r_held.od_dn   <= 1'b0;
          SC_SUSTAIN: r_held.sustain <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  ps2_voice_alloc #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W)
  ) u_voice_alloc (
    .i_clk          (CLOCK_50),
    .i_reset        (reset),
    .i_make         (w_plain_make && w_lookup.hit),
    .i_break        (w_plain_break && w_lookup.hit),
    .i_note         (NOTE_W'(w_lookup.note)),
    .i_sustain      (r_sustain),
    .i_sustain_fall (w_sustain_fall),
    .o_voice_valid  (voice_valid),
    .o_voice_note   (voice_note),
    .o_voice_trig   (voice_trig),
    .o_note_drop    (note_drop)
  );

  assign octave    = r_octave;
  assign adsr_sel  = r_adsr_sel;
  assign adsr_inc  = r_adsr_inc;
  assign adsr_dec  = r_adsr_dec;
  assign sine      = r_sine;
  assign overdrive = r_overdrive;
  assign sustain   = r_sustain;

endmodule
